// File: rtl/bool_truth_table_scanner.sv
// Steps an N_IN-input combinational block through every vector and captures its truth table against an expected one.
// Latency: 2**N_IN*(SETTLE_CYC+1) cycles from the start-accepting edge, then a one-cycle done pulse.
// Backpressure: none; start is honoured only in IDLE and ignored while busy.
module bool_truth_table_scanner #(
    parameter int N_IN       = 3,
    parameter int SETTLE_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        vec_out,
    input  logic                   f_in,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   truth_table,
    output logic                   mismatch,
    output logic [N_IN:0]          err_count,
    output logic [N_IN-1:0]        first_err_idx
);

    localparam int NV = 1 << N_IN;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N_IN-1:0] idx;
    logic [SW-1:0]   settle_cnt;
    logic [NV-1:0]   exp_q;
    logic            last_vec;
    logic            settle_end;
    logic            f_diff;

    assign last_vec   = (idx == N_IN'(NV - 1));
    assign settle_end = (settle_cnt == SW'(SETTLE_CYC - 1));
    assign f_diff     = (f_in != exp_q[idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (settle_end) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last_vec ? DONE : SETTLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        vec_out = idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx           <= '0;
            settle_cnt    <= '0;
            exp_q         <= '0;
            truth_table   <= '0;
            mismatch      <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q         <= expected;
                        truth_table   <= '0;
                        mismatch      <= 1'b0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        idx           <= '0;
                        settle_cnt    <= '0;
                    end
                end
                SETTLE: begin
                    if (!settle_end) settle_cnt <= settle_cnt + 1'b1;
                end
                SAMPLE: begin
                    truth_table[idx] <= f_in;
                    if (f_diff) begin
                        err_count <= err_count + 1'b1;
                        mismatch  <= 1'b1;
                        if (!mismatch) first_err_idx <= idx;
                    end
                    // terminal vector is held so vec_out keeps it through DONE
                    if (!last_vec) idx <= idx + 1'b1;
                    settle_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bool_truth_table_scanner.sv
module tb_bool_truth_table_scanner;

    typedef struct {
        logic [7:0] tt;
        logic       mm;
        logic [3:0] ec;
        logic [2:0] fei;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    exp_t sb_a[$];
    exp_t sb_b[$];

    // default instance: N_IN=3, SETTLE_CYC=2
    logic       a_start = 1'b0;
    logic [7:0] a_expected = '0;
    logic [2:0] a_vec;
    logic       a_fin;
    logic       a_busy, a_done, a_mm;
    logic [7:0] a_tt;
    logic [3:0] a_ec;
    logic [2:0] a_fei;

    assign a_fin = (a_vec[2] & a_vec[1]) | ~a_vec[0];

    bool_truth_table_scanner #(.N_IN(3), .SETTLE_CYC(2)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .expected(a_expected),
        .vec_out(a_vec), .f_in(a_fin), .busy(a_busy), .done(a_done),
        .truth_table(a_tt), .mismatch(a_mm), .err_count(a_ec),
        .first_err_idx(a_fei)
    );

    // corner instance: N_IN=1, SETTLE_CYC=1, f = ~x
    logic       b_start = 1'b0;
    logic [1:0] b_expected = '0;
    logic [0:0] b_vec;
    logic       b_fin;
    logic       b_busy, b_done, b_mm;
    logic [1:0] b_tt;
    logic [1:0] b_ec;
    logic [0:0] b_fei;

    assign b_fin = ~b_vec[0];

    bool_truth_table_scanner #(.N_IN(1), .SETTLE_CYC(1)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .expected(b_expected),
        .vec_out(b_vec), .f_in(b_fin), .busy(b_busy), .done(b_done),
        .truth_table(b_tt), .mismatch(b_mm), .err_count(b_ec),
        .first_err_idx(b_fei)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [7:0] tt,
                           input logic mm, input logic [3:0] ec, input logic [2:0] fei);
        check({tag, " done_cycle"}, cyc, e.cyc);
        check({tag, " truth_table"}, {24'b0, tt}, {24'b0, e.tt});
        check({tag, " mismatch"}, {31'b0, mm}, {31'b0, e.mm});
        check({tag, " err_count"}, {28'b0, ec}, {28'b0, e.ec});
        if (e.mm) check({tag, " first_err_idx"}, {29'b0, fei}, {29'b0, e.fei});
    endtask

    always @(negedge clk) begin
        if (a_done) begin
            check("a done_expected", {31'b0, sb_a.size() > 0}, 32'd1);
            if (sb_a.size() > 0) compare("a", sb_a.pop_front(), a_tt, a_mm, a_ec, a_fei);
        end
        if (b_done) begin
            check("b done_expected", {31'b0, sb_b.size() > 0}, 32'd1);
            if (sb_b.size() > 0)
                compare("b", sb_b.pop_front(), {6'b0, b_tt}, b_mm, {2'b0, b_ec}, {2'b0, b_fei});
        end
    end

    task automatic wait_a_idle();
        for (int i = 0; i < 60 && a_busy; i++) @(negedge clk);
        check("a scan_end busy", {31'b0, a_busy}, 32'd0);
        check("a sb_drained", sb_a.size(), 32'd0);
    endtask

    task automatic scan_a(input logic [7:0] exp_tbl, input logic [7:0] tt, input logic mm,
                          input logic [3:0] ec, input logic [2:0] fei);
        @(negedge clk);
        a_expected = exp_tbl;
        a_start    = 1'b1;
        sb_a.push_back('{tt: tt, mm: mm, ec: ec, fei: fei, cyc: cyc + 25});
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            a_start = 1'b0;
            if (j == 5) a_expected = ~exp_tbl;
            check("a vec_seq", {29'b0, a_vec}, (j - 1) / 3);
            check("a busy_scan", {31'b0, a_busy}, 32'd1);
        end
        wait_a_idle();
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, " vec_out"}, {29'b0, a_vec}, 32'd0);
        check({tag, " busy"}, {31'b0, a_busy}, 32'd0);
        check({tag, " done"}, {31'b0, a_done}, 32'd0);
        check({tag, " truth_table"}, {24'b0, a_tt}, 32'd0);
        check({tag, " mismatch"}, {31'b0, a_mm}, 32'd0);
        check({tag, " err_count"}, {28'b0, a_ec}, 32'd0);
        check({tag, " first_err_idx"}, {29'b0, a_fei}, 32'd0);
    endtask

    int k;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_a_zero("reset");
        check("b reset busy", {31'b0, b_busy}, 32'd0);
        check("b reset truth_table", {30'b0, b_tt}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle busy", {31'b0, a_busy}, 32'd0);
            check("idle vec_out", {29'b0, a_vec}, 32'd0);
        end

        scan_a(8'hD5, 8'hD5, 1'b0, 4'd0, 3'd0);
        scan_a(8'hD4, 8'hD5, 1'b1, 4'd1, 3'd0);
        repeat (10) @(negedge clk);
        check("hold truth_table", {24'b0, a_tt}, 32'hD5);
        check("hold err_count", {28'b0, a_ec}, 32'd1);
        scan_a(8'h2A, 8'hD5, 1'b1, 4'd8, 3'd0);
        scan_a(8'hC5, 8'hD5, 1'b1, 4'd1, 3'd4);

        // start while busy at vector 3, then reset at vector 5
        @(negedge clk);
        a_expected = 8'h2A;
        a_start    = 1'b1;
        k = cyc;
        sb_a.push_back('{tt: 8'hD5, mm: 1'b1, ec: 4'd8, fei: 3'd0, cyc: cyc + 25});
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 40 && a_vec != 3'd3; i++) @(negedge clk);
        check("abort reach_vec3", cyc - k, 32'd10);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 40 && a_vec != 3'd5; i++) @(negedge clk);
        check("abort reach_vec5", cyc - k, 32'd16);
        check("abort pre_mismatch", {31'b0, a_mm}, 32'd1);
        rst = 1'b1;
        sb_a.delete();
        @(negedge clk);
        rst = 1'b0;
        check_a_zero("abort");
        repeat (30) @(negedge clk);
        check("abort stays_idle", {31'b0, a_busy}, 32'd0);
        scan_a(8'hD5, 8'hD5, 1'b0, 4'd0, 3'd0);

        // N_IN=1, SETTLE_CYC=1: f=~x gives table 2'b01
        @(negedge clk);
        b_expected = 2'b01;
        b_start    = 1'b1;
        sb_b.push_back('{tt: 8'h01, mm: 1'b0, ec: 4'd0, fei: 3'd0, cyc: cyc + 5});
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            b_start = 1'b0;
            check("b vec_seq", {31'b0, b_vec}, (j - 1) / 2);
        end
        repeat (3) @(negedge clk);
        check("b sb_drained1", sb_b.size(), 32'd0);

        // start held high: second scan accepted in the idle cycle after done
        @(negedge clk);
        b_expected = 2'b11;
        b_start    = 1'b1;
        k = cyc;
        sb_b.push_back('{tt: 8'h01, mm: 1'b1, ec: 4'd1, fei: 3'd1, cyc: k + 5});
        sb_b.push_back('{tt: 8'h01, mm: 1'b1, ec: 4'd1, fei: 3'd1, cyc: k + 11});
        for (int i = 0; i < 20 && cyc < k + 6; i++) @(negedge clk);
        check("b b2b idle_gap", {31'b0, b_busy}, 32'd0);
        check("b b2b hold_mismatch", {31'b0, b_mm}, 32'd1);
        @(negedge clk);
        check("b b2b busy_again", {31'b0, b_busy}, 32'd1);
        check("b b2b tt_cleared", {30'b0, b_tt}, 32'd0);
        check("b b2b mm_cleared", {31'b0, b_mm}, 32'd0);
        check("b b2b ec_cleared", {30'b0, b_ec}, 32'd0);
        b_start = 1'b0;
        for (int i = 0; i < 20 && (b_busy || sb_b.size() > 0); i++) @(negedge clk);
        check("b sb_drained2", sb_b.size(), 32'd0);
        check("b final busy", {31'b0, b_busy}, 32'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
